// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types, defaults and address classifier for dmem_arbiter
package dmem_arbiter_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } state_t;

    typedef enum logic [1:0] {
        CL_RAM,
        CL_LED,
        CL_BAD
    } addr_class_t;

    localparam int unsigned MEM_BYTES_DEF = 64;
    localparam int unsigned LED_BASE_DEF  = 32'h2000;
    localparam int unsigned LED_COUNT_DEF = 4;
    localparam logic [15:0] PARK_ADDR_DEF = 16'h0000;

    // Widened to 32 bits so LED_BASE + LED_COUNT cannot wrap at the top of the map.
    function automatic addr_class_t classify(
        input logic [15:0] addr,
        input int unsigned mem_bytes,
        input int unsigned led_base,
        input int unsigned led_count
    );
        logic [31:0] a;
        a = {16'h0000, addr};
        if (a < mem_bytes)
            return CL_RAM;
        if (a >= led_base && a < led_base + led_count)
            return CL_LED;
        return CL_BAD;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - combinational 2-way round-robin picker
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       gnt_id,
    output logic       valid
);

    assign valid  = |req;
    assign gnt_id = (req == 2'b11) ? ptr : req[1];

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - serialises two requesters onto one data-memory port
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
    parameter int unsigned LED_BASE  = LED_BASE_DEF,
    parameter int unsigned LED_COUNT = LED_COUNT_DEF,
    parameter logic [15:0] PARK_ADDR = PARK_ADDR_DEF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic        m0_size,
    input  logic [15:0] m0_addr,
    input  logic [15:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [15:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic        m1_size,
    input  logic [15:0] m1_addr,
    input  logic [15:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [15:0] m1_rdata,
    output logic        wmem,
    output logic        memc,
    output logic [15:0] DAddress,
    output logic [15:0] DataIn,
    input  logic [15:0] DataOut,
    output logic        busy
);

    state_t      state;
    logic        rr_ptr;
    logic        lat_id;
    logic        lat_we;
    logic        lat_size;
    addr_class_t lat_cls;

    logic        gnt_id;
    logic        arb_valid;
    logic        sel_we;
    logic        sel_size;
    logic [15:0] sel_addr;
    logic [15:0] sel_wdata;
    addr_class_t sel_cls;
    logic [15:0] rd_val;
    logic        rd_update;
    logic        is_bad;

    rr_arb2 u_rr_arb2 (
        .req    ({m1_req, m0_req}),
        .ptr    (rr_ptr),
        .gnt_id (gnt_id),
        .valid  (arb_valid)
    );

    assign sel_we    = gnt_id ? m1_we    : m0_we;
    assign sel_size  = gnt_id ? m1_size  : m0_size;
    assign sel_addr  = gnt_id ? m1_addr  : m0_addr;
    assign sel_wdata = gnt_id ? m1_wdata : m0_wdata;
    assign sel_cls   = classify(sel_addr, MEM_BYTES, LED_BASE, LED_COUNT);

    assign busy   = (state == ST_ACCESS);
    assign is_bad = (lat_cls == CL_BAD);

    // LED reads and rejected accesses return zero; writes leave rdata untouched unless rejected.
    always_comb begin
        rd_val    = 16'h0000;
        rd_update = !lat_we || is_bad;
        if (lat_cls == CL_RAM)
            rd_val = lat_size ? DataOut : {8'h00, DataOut[7:0]};
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= ST_IDLE;
            rr_ptr   <= 1'b0;
            lat_id   <= 1'b0;
            lat_we   <= 1'b0;
            lat_size <= 1'b0;
            lat_cls  <= CL_BAD;
            m0_ack   <= 1'b0;
            m0_err   <= 1'b0;
            m0_rdata <= 16'h0000;
            m1_ack   <= 1'b0;
            m1_err   <= 1'b0;
            m1_rdata <= 16'h0000;
            wmem     <= 1'b0;
            memc     <= 1'b0;
            DAddress <= PARK_ADDR;
            DataIn   <= 16'h0000;
        end else begin
            m0_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_ack <= 1'b0;
            m1_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        lat_id   <= gnt_id;
                        lat_we   <= sel_we;
                        lat_size <= sel_size;
                        lat_cls  <= sel_cls;
                        rr_ptr   <= ~gnt_id;
                        state    <= ST_ACCESS;
                        // Memory outputs are registered here so they are stable for the whole ACCESS cycle.
                        if (sel_cls == CL_RAM) begin
                            DAddress <= sel_addr;
                            memc     <= sel_size;
                            DataIn   <= sel_wdata;
                            wmem     <= sel_we;
                        end else if (sel_cls == CL_LED && sel_we) begin
                            DAddress <= sel_addr;
                            DataIn   <= sel_wdata;
                            wmem     <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    wmem     <= 1'b0;
                    memc     <= 1'b0;
                    DAddress <= PARK_ADDR;
                    DataIn   <= 16'h0000;
                    state    <= ST_IDLE;
                    if (lat_id) begin
                        m1_ack <= 1'b1;
                        m1_err <= is_bad;
                        if (rd_update)
                            m1_rdata <= rd_val;
                    end else begin
                        m0_ack <= 1'b1;
                        m0_err <= is_bad;
                        if (rd_update)
                            m0_rdata <= rd_val;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a byte-addressed memory model
module tb_dmem_arbiter;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0, m0_size = 1'b0;
    logic [15:0] m0_addr = 16'h0, m0_wdata = 16'h0;
    logic        m1_req = 1'b0, m1_we = 1'b0, m1_size = 1'b0;
    logic [15:0] m1_addr = 16'h0, m1_wdata = 16'h0;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [15:0] m0_rdata, m1_rdata;
    logic        wmem, memc, busy;
    logic [15:0] DAddress, DataIn, DataOut;

    dmem_arbiter dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_size  (m0_size),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_ack   (m0_ack),
        .m0_err   (m0_err),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_size  (m1_size),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_ack   (m1_ack),
        .m1_err   (m1_err),
        .m1_rdata (m1_rdata),
        .wmem     (wmem),
        .memc     (memc),
        .DAddress (DAddress),
        .DataIn   (DataIn),
        .DataOut  (DataOut),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    logic [7:0]  mem [64];
    logic [15:0] leds [4];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        for (int i = 0; i < 4; i++) leds[i] = 16'h0000;
    end

    always @(posedge CLK) begin
        if (wmem) begin
            if (DAddress < 16'd64) begin
                if (memc) begin
                    mem[{DAddress[5:1], 1'b0}] <= DataIn[7:0];
                    mem[{DAddress[5:1], 1'b1}] <= DataIn[15:8];
                end else begin
                    mem[DAddress[5:0]] <= DataIn[7:0];
                end
            end else if (DAddress >= 16'h2000 && DAddress < 16'h2004) begin
                leds[DAddress[1:0]] <= DataIn;
            end
        end
    end

    always_comb begin
        DataOut = 16'h0000;
        if (DAddress < 16'd64)
            DataOut = memc ? {mem[{DAddress[5:1], 1'b1}], mem[{DAddress[5:1], 1'b0}]}
                           : {8'h00, mem[DAddress[5:0]]};
    end

    typedef struct {
        logic        id;
        logic        err;
        logic [15:0] rdata;
        logic        chk_rd;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_miss = 0;
    logic wmem_idle = 1'b0;
    logic saw_wmem = 1'b0;
    logic saw_off_park = 1'b0;
    logic led_rd_drive = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (m0_ack || m1_ack) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_ack: got m0_ack=%b m1_ack=%b expected none", m0_ack, m1_ack);
            end else begin
                mon_e = sb.pop_front();
                check("ack_port", {30'h0, m1_ack, m0_ack}, mon_e.id ? 32'h2 : 32'h1);
                check("ack_err", {31'h0, mon_e.id ? m1_err : m0_err}, {31'h0, mon_e.err});
                if (mon_e.chk_rd)
                    check("rdata", {16'h0, mon_e.id ? m1_rdata : m0_rdata}, {16'h0, mon_e.rdata});
            end
        end
        if (wmem && !busy) wmem_idle = 1'b1;
        if (wmem) saw_wmem = 1'b1;
        if (DAddress != 16'h0000) saw_off_park = 1'b1;
        if (DAddress >= 16'h2000 && DAddress < 16'h2004 && !wmem) led_rd_drive = 1'b1;
    end

    task automatic access(input logic id, input logic we, input logic size,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          input logic exp_err, input logic [15:0] exp_rd, input logic chk_rd);
        int   lat;
        logic got;
        @(negedge CLK);
        sb.push_back('{id: id, err: exp_err, rdata: exp_rd, chk_rd: chk_rd});
        if (id) begin
            m1_req = 1'b1; m1_we = we; m1_size = size; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_size = size; m0_addr = addr; m0_wdata = wdata;
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 10) begin
            @(negedge CLK);
            lat++;
            got = id ? m1_ack : m0_ack;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        check("ack_latency", lat, 2);
    endtask

    // Both ports hold a read request until n grants have been acknowledged; M0 expected first.
    task automatic contend(input int n, input logic [15:0] exp0, input logic [15:0] exp1);
        int cnt;
        int cyc;
        @(negedge CLK);
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 0) sb.push_back('{id: 1'b0, err: 1'b0, rdata: exp0, chk_rd: 1'b1});
            else            sb.push_back('{id: 1'b1, err: 1'b0, rdata: exp1, chk_rd: 1'b1});
        end
        m0_we = 1'b0; m0_size = 1'b1; m0_addr = 16'h0004;
        m1_we = 1'b0; m1_size = 1'b0; m1_addr = 16'h0005;
        m0_req = 1'b1;
        m1_req = 1'b1;
        cnt = 0;
        cyc = 0;
        while (cnt < n && cyc < 10 * n) begin
            @(negedge CLK);
            cyc++;
            if (m0_ack || m1_ack) cnt++;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        check("contend_grants", cnt, n);
    endtask

    initial begin
        #1;
        check("rst_wmem", {31'h0, wmem}, 0);
        check("rst_daddr", {16'h0, DAddress}, 32'h0000);
        check("rst_busy_ack", {28'h0, busy, m0_ack, m1_ack, m0_err | m1_err}, 0);
        check("rst_rdata", {m0_rdata, m1_rdata}, 0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;

        access(1'b0, 1'b1, 1'b1, 16'h0004, 16'hBEEF, 1'b0, 16'h0, 1'b0);
        check("mem4", {24'h0, mem[4]}, 32'hEF);
        check("mem5", {24'h0, mem[5]}, 32'hBE);
        access(1'b0, 1'b0, 1'b1, 16'h0004, 16'h0, 1'b0, 16'hBEEF, 1'b1);

        access(1'b1, 1'b1, 1'b1, 16'h2002, 16'h0001, 1'b0, 16'h0, 1'b0);
        check("dig3", {16'h0, leds[2]}, 32'h0001);
        led_rd_drive = 1'b0;
        access(1'b1, 1'b0, 1'b1, 16'h2002, 16'h0, 1'b0, 16'h0000, 1'b1);
        check("led_read_parked", {31'h0, led_rd_drive}, 0);

        contend(4, 16'hBEEF, 16'h00BE);

        saw_wmem = 1'b0;
        saw_off_park = 1'b0;
        access(1'b0, 1'b0, 1'b1, 16'h0100, 16'h0, 1'b1, 16'h0000, 1'b1);
        check("bad_no_wmem", {31'h0, saw_wmem}, 0);
        check("bad_parked", {31'h0, saw_off_park}, 0);

        access(1'b1, 1'b1, 1'b0, 16'h003F, 16'h00A5, 1'b0, 16'h0, 1'b0);
        access(1'b1, 1'b0, 1'b0, 16'h003F, 16'h0, 1'b0, 16'h00A5, 1'b1);
        access(1'b0, 1'b0, 1'b0, 16'h0040, 16'h0, 1'b1, 16'h0000, 1'b1);
        access(1'b1, 1'b1, 1'b1, 16'h2003, 16'h0007, 1'b0, 16'h0, 1'b0);
        check("dig4", {16'h0, leds[3]}, 32'h0007);
        access(1'b1, 1'b1, 1'b1, 16'h2004, 16'hFFFF, 1'b1, 16'h0, 1'b0);

        access(1'b0, 1'b1, 1'b0, 16'h0003, 16'h005A, 1'b0, 16'h0, 1'b0);
        check("mem3", {24'h0, mem[3]}, 32'h5A);
        access(1'b1, 1'b0, 1'b1, 16'h0003, 16'h0, 1'b0, 16'h5A00, 1'b1);

        @(negedge CLK);
        m0_req = 1'b1; m0_we = 1'b1; m0_size = 1'b1; m0_addr = 16'h0008; m0_wdata = 16'h1234;
        @(posedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        check("midrst_wmem", {31'h0, wmem}, 0);
        check("midrst_daddr", {16'h0, DAddress}, 32'h0000);
        check("midrst_busy", {31'h0, busy}, 0);
        m0_req = 1'b0;
        repeat (2) @(negedge CLK);
        check("midrst_mem8", {mem[9], mem[8]}, 0);
        RESET = 1'b1;
        @(negedge CLK);
        check("post_rst_busy", {31'h0, busy}, 0);
        contend(2, 16'hBEEF, 16'h00BE);

        repeat (3) @(negedge CLK);
        check("sb_empty", sb.size(), 0);
        check("wmem_outside_access", {31'h0, wmem_idle}, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
